// File: rtl/sc_key_debouncer.sv
// sc_key_debouncer: synchronizes and debounces the 9 raw board keys.
// Each key gets a two-stage synchronizer, then a counter that must see the
// synchronized level disagree with the accepted level for STABLE_CYCLES
// consecutive cycles before the new level is accepted. Level changes also
// produce one-cycle press/release pulses.
module sc_key_debouncer #(
  parameter int STABLE_CYCLES = 50000,
  parameter int CNT_W         = 16,
  parameter int ACTIVE_LOW    = 1
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [8:0] key_raw,
  output logic       key1,
  output logic [3:0] key2,
  output logic [3:0] key3,
  output logic [8:0] press_evt,
  output logic [8:0] release_evt
);

  localparam int NKEYS = 9;

  // Raw level of a key that is not pressed; synchronizers reset to this so
  // that leaving reset never looks like a press.
  localparam logic [NKEYS-1:0] IDLE_RAW = (ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [NKEYS-1:0] POL_MASK = (ACTIVE_LOW != 0) ? '1 : '0;

  // Terminal count: reaching it while the level still disagrees accepts it.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CYCLES - 1);

  logic [NKEYS-1:0]            sync1_reg;
  logic [NKEYS-1:0]            sync2_reg;
  logic [NKEYS-1:0]            s;
  logic [NKEYS-1:0]            stable_reg;
  logic [NKEYS-1:0]            stable_next;
  logic [NKEYS-1:0]            press_reg;
  logic [NKEYS-1:0]            press_next;
  logic [NKEYS-1:0]            release_reg;
  logic [NKEYS-1:0]            release_next;
  logic [NKEYS-1:0]            hit;
  logic [NKEYS-1:0]            same;
  logic [NKEYS-1:0][CNT_W-1:0] cnt_reg;
  logic [NKEYS-1:0][CNT_W-1:0] cnt_next;

  // Two-flop synchronizer for the asynchronous key pins.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1_reg <= IDLE_RAW;
      sync2_reg <= IDLE_RAW;
    end else begin
      sync1_reg <= key_raw;
      sync2_reg <= sync1_reg;
    end
  end

  // Active-high synchronized level.
  assign s = sync2_reg ^ POL_MASK;

  // Per-key debounce decision, fully independent between keys.
  genvar gi;
  generate
    for (gi = 0; gi < NKEYS; gi++) begin : g_key
      // Level agrees with the accepted one: any partial count is abandoned.
      assign same[gi] = (s[gi] == stable_reg[gi]);
      // Disagreement has persisted long enough: accept the new level now.
      assign hit[gi]  = !same[gi] && (cnt_reg[gi] == LAST_CNT);

      // Counter clears on agreement or acceptance, so it never passes LAST_CNT.
      assign cnt_next[gi]     = (same[gi] || hit[gi]) ? '0 : cnt_reg[gi] + CNT_W'(1);
      assign stable_next[gi]  = hit[gi] ? s[gi] : stable_reg[gi];
      assign press_next[gi]   = hit[gi] &&  s[gi];
      assign release_next[gi] = hit[gi] && !s[gi];
    end
  endgenerate

  // Debounce state and registered event pulses.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_reg     <= '0;
      stable_reg  <= '0;
      press_reg   <= '0;
      release_reg <= '0;
    end else begin
      cnt_reg     <= cnt_next;
      stable_reg  <= stable_next;
      press_reg   <= press_next;
      release_reg <= release_next;
    end
  end

  assign key1        = stable_reg[0];
  assign key2        = stable_reg[4:1];
  assign key3        = stable_reg[8:5];
  assign press_evt   = press_reg;
  assign release_evt = release_reg;

endmodule

// File: tb/tb_sc_key_debouncer.sv
// tb_sc_key_debouncer: random key activity (clean holds, short glitches,
// simultaneous multi-key changes, random resets) compared every cycle with a
// behavioural model: a key's accepted level flips once the last STABLE
// synchronized samples all disagree with it.
module tb_sc_key_debouncer;

  localparam int SC = 4;

  logic       clock;
  logic       resetn;
  logic [8:0] key_raw;
  logic       key1;
  logic [3:0] key2;
  logic [3:0] key3;
  logic [8:0] press_evt;
  logic [8:0] release_evt;

  int total = 0;
  int bad   = 0;

  sc_key_debouncer #(
    .STABLE_CYCLES(SC),
    .CNT_W        (3),
    .ACTIVE_LOW   (1)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .key_raw    (key_raw),
    .key1       (key1),
    .key2       (key2),
    .key3       (key3),
    .press_evt  (press_evt),
    .release_evt(release_evt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Model state: raw pressed-level samples in flight, recent synchronized
  // samples, accepted level and expected pulses.
  logic [8:0] m_p1, m_p2;
  logic [8:0] m_win [SC];
  logic [8:0] m_stable, m_press, m_rel;

  task automatic check_val(input string tag, input logic [8:0] got, input logic [8:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%03h exp=%03h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_p1 = '0;
    m_p2 = '0;
    for (int i = 0; i < SC; i++) m_win[i] = '0;
    m_stable = '0;
    m_press  = '0;
    m_rel    = '0;
  endtask

  // One rising edge with reset released.
  task automatic model_step(input logic [8:0] raw);
    logic [8:0] flip;
    for (int i = SC - 1; i > 0; i--) m_win[i] = m_win[i-1];
    m_win[0] = m_p2;
    flip = '1;
    for (int i = 0; i < SC; i++) flip &= (m_win[i] ^ m_stable);
    m_press  = flip & ~m_stable;
    m_rel    = flip &  m_stable;
    m_stable = m_stable ^ flip;
    m_p2 = m_p1;
    m_p1 = ~raw;
  endtask

  task automatic check_all(input string tag);
    check_val({tag, "_level"},   {key3, key2, key1}, m_stable);
    check_val({tag, "_press"},   press_evt,          m_press);
    check_val({tag, "_release"}, release_evt,        m_rel);
  endtask

  int hold [9];
  int rst_hold;

  initial begin
    resetn  = 1'b0;
    key_raw = 9'h1FF;
    model_reset();
    rst_hold = 0;
    for (int b = 0; b < 9; b++) hold[b] = $urandom_range(1, 10);
    repeat (3) @(posedge clock);
    #1 check_all("reset");
    @(negedge clock);
    resetn = 1'b1;

    // Keys idle after reset: nothing may change or pulse.
    for (int c = 0; c < 20; c++) begin
      @(posedge clock);
      #1;
      model_step(key_raw);
      check_all("idle");
    end

    for (int c = 0; c < 4000; c++) begin
      @(negedge clock);
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) resetn = 1'b1;
      end else if ($urandom_range(0, 299) == 0) begin
        resetn = 1'b0;
        rst_hold = $urandom_range(1, 3);
        model_reset();
        #1 check_all("async_rst");
      end

      if ($urandom_range(0, 59) == 0) begin
        // Several keys change together and hold long enough to be accepted.
        key_raw = $urandom_range(0, 1) ? 9'h000 : 9'h1FF;
        for (int b = 0; b < 9; b++) hold[b] = SC + 4;
      end else begin
        for (int b = 0; b < 9; b++) begin
          hold[b]--;
          if (hold[b] <= 0) begin
            key_raw[b] = ~key_raw[b];
            hold[b] = $urandom_range(1, 10);
          end
        end
      end

      @(posedge clock);
      #1;
      if (resetn) model_step(key_raw);
      check_all("run");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
